// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, reset words and scheduler state for the PWM slew scheduler
package pwm_pkg;

    localparam int CH   = 4;
    localparam int CCW  = 24;
    localparam int DIVW = 16;

    localparam logic [CCW-1:0] PWM_RST_A = 24'h0F0000;
    localparam logic [CCW-1:0] PWM_RST_B = 24'h4E0000;
    localparam logic [CCW-1:0] PWM_RST_C = 24'h750000;
    localparam logic [CCW-1:0] PWM_RST_D = 24'h9C0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN0 = 3'd1,
        ST_SCAN1 = 3'd2,
        ST_SCAN2 = 3'd3,
        ST_SCAN3 = 3'd4
    } sched_st_t;

    function automatic logic [CCW-1:0] pwm_rst_val(input logic [1:0] ch);
        case (ch)
            2'd0:    return PWM_RST_A;
            2'd1:    return PWM_RST_B;
            2'd2:    return PWM_RST_C;
            default: return PWM_RST_D;
        endcase
    endfunction

endpackage

// File: rtl/pwm_slew_step.sv
// rtl/pwm_slew_step.sv - one bounded step of cur toward tgt, never overshooting
module pwm_slew_step
    import pwm_pkg::*;
(
    input  logic [CCW-1:0] cur,
    input  logic [CCW-1:0] tgt,
    input  logic [CCW-1:0] step,
    output logic [CCW-1:0] next,
    output logic           changed
);

    logic [CCW:0] diff;

    // Magnitude is taken in CCW+1 bits so the clamp against step can never wrap
    always_comb begin
        next = cur;
        diff = '0;
        if ({1'b0, cur} < {1'b0, tgt}) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            next = cur + ((diff > {1'b0, step}) ? step : diff[CCW-1:0]);
        end else if ({1'b0, cur} > {1'b0, tgt}) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            next = cur - ((diff > {1'b0, step}) ? step : diff[CCW-1:0]);
        end
        changed = (next != cur);
    end

endmodule

// File: rtl/pwm_slew_sched.sv
// rtl/pwm_slew_sched.sv - round-robin slew-rate scheduler for four PWM DAC configuration words
module pwm_slew_sched
    import pwm_pkg::*;
(
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            en_i,
    input  logic [DIVW-1:0] div_i,
    input  logic [CCW-1:0]  step_i,
    input  logic            tgt_wr_i,
    input  logic [1:0]      tgt_ch_i,
    input  logic [CCW-1:0]  tgt_val_i,
    output logic [CCW-1:0]  dac_a_o,
    output logic [CCW-1:0]  dac_b_o,
    output logic [CCW-1:0]  dac_c_o,
    output logic [CCW-1:0]  dac_d_o,
    output logic            busy_o,
    output logic            upd_o,
    output logic [1:0]      upd_ch_o,
    output logic            ovr_o
);

    logic [DIVW-1:0] cnt;
    logic            tick;
    sched_st_t       state, state_nx;
    logic            pend, pend_nx;
    logic            ovr_nx;
    logic            scanning;
    logic [1:0]      idx;
    logic [CCW-1:0]  cur [CH];
    logic [CCW-1:0]  tgt [CH];
    logic [CCW-1:0]  step_next;
    logic            step_changed;
    logic            busy_nx;

    // >= rather than == so a div_i lowered mid-count still wraps promptly
    assign tick = en_i && (cnt >= div_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt <= '0;
        end else if (!en_i || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
            pend  <= 1'b0;
            ovr_o <= 1'b0;
        end else begin
            state <= state_nx;
            pend  <= pend_nx;
            ovr_o <= ovr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        ovr_nx   = 1'b0;
        scanning = (state != ST_IDLE);
        idx      = 2'd0;
        case (state)
            ST_IDLE: begin
                if (en_i && (tick || pend)) begin
                    state_nx = ST_SCAN0;
                    pend_nx  = 1'b0;
                end
            end
            ST_SCAN0: begin state_nx = ST_SCAN1; idx = 2'd0; end
            ST_SCAN1: begin state_nx = ST_SCAN2; idx = 2'd1; end
            ST_SCAN2: begin state_nx = ST_SCAN3; idx = 2'd2; end
            ST_SCAN3: begin state_nx = ST_IDLE;  idx = 2'd3; end
            default:  state_nx = ST_IDLE;
        endcase
        // Only one tick can wait behind a scan; any further one is lost
        if (!en_i) begin
            pend_nx = 1'b0;
            if (scanning) state_nx = ST_IDLE;
        end else if (scanning && tick) begin
            if (pend) ovr_nx = 1'b1;
            else      pend_nx = 1'b1;
        end
    end

    pwm_slew_step u_step (
        .cur     (cur[idx]),
        .tgt     (tgt[idx]),
        .step    (step_i),
        .next    (step_next),
        .changed (step_changed)
    );

    always_comb begin
        busy_nx = 1'b0;
        for (int k = 0; k < CH; k++) begin
            busy_nx = busy_nx | (cur[k] != tgt[k]);
        end
    end

    // A target written in the cycle its channel is scanned lands after the step reads it
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < CH; k++) begin
                cur[k] <= pwm_rst_val(2'(k));
                tgt[k] <= pwm_rst_val(2'(k));
            end
            busy_o   <= 1'b0;
            upd_o    <= 1'b0;
            upd_ch_o <= 2'd0;
        end else begin
            if (tgt_wr_i) tgt[tgt_ch_i] <= tgt_val_i;
            if (scanning) begin
                cur[idx] <= step_next;
                upd_ch_o <= idx;
            end
            upd_o  <= scanning && step_changed;
            busy_o <= busy_nx;
        end
    end

    assign dac_a_o = cur[0];
    assign dac_b_o = cur[1];
    assign dac_c_o = cur[2];
    assign dac_d_o = cur[3];

endmodule

// File: tb/tb_pwm_slew_sched.sv
// tb/tb_pwm_slew_sched.sv - directed self-checking bench for pwm_slew_sched
module tb_pwm_slew_sched;
    import pwm_pkg::*;

    logic            clk = 1'b0;
    logic            rstn;
    logic            en;
    logic [DIVW-1:0] div;
    logic [CCW-1:0]  step;
    logic            tgt_wr;
    logic [1:0]      tgt_ch;
    logic [CCW-1:0]  tgt_val;
    logic [CCW-1:0]  dac_a, dac_b, dac_c, dac_d;
    logic            busy, upd, ovr;
    logic [1:0]      upd_ch;

    int n_checks = 0;
    int n_errors = 0;

    pwm_slew_sched dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .en_i      (en),
        .div_i     (div),
        .step_i    (step),
        .tgt_wr_i  (tgt_wr),
        .tgt_ch_i  (tgt_ch),
        .tgt_val_i (tgt_val),
        .dac_a_o   (dac_a),
        .dac_b_o   (dac_b),
        .dac_c_o   (dac_c),
        .dac_d_o   (dac_d),
        .busy_o    (busy),
        .upd_o     (upd),
        .upd_ch_o  (upd_ch),
        .ovr_o     (ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_tgt(input logic [1:0] c, input logic [CCW-1:0] v);
        tgt_wr  = 1'b1;
        tgt_ch  = c;
        tgt_val = v;
        cyc();
        tgt_wr  = 1'b0;
    endtask

    task automatic wait_upd(input int maxc, output int n);
        bit seen = 1'b0;
        n = 0;
        for (int i = 0; i < maxc; i++) begin
            cyc();
            n++;
            if (upd) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("upd_timeout", 32'd0, 32'd1);
    endtask

    task automatic quiet(input int cycles, input string tag);
        int cnt_upd = 0;
        for (int i = 0; i < cycles; i++) begin
            cyc();
            if (upd) cnt_upd++;
        end
        check(tag, cnt_upd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [23:0] up_exp [4] = '{24'h100000, 24'h110000, 24'h120000, 24'h130000};
    logic [23:0] dn_exp [4] = '{24'h6C0000, 24'h3C0000, 24'h0C0000, 24'h000001};
    bit          ovr_exp [1:10] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
    bit          ovr_r [1:10];
    bit          upd_r [1:10];
    logic [23:0] dacc_r [1:10];

    initial begin
        int n;
        int upd_cnt;
        rstn = 1'b0; en = 1'b0; div = '0; step = '0;
        tgt_wr = 1'b0; tgt_ch = 2'd0; tgt_val = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        cyc();

        // Reset state
        check("rst_dac_a", dac_a, 32'h0F0000);
        check("rst_dac_b", dac_b, 32'h4E0000);
        check("rst_dac_c", dac_c, 32'h750000);
        check("rst_dac_d", dac_d, 32'h9C0000);
        check("rst_busy", busy, 0);
        check("rst_upd", upd, 0);
        check("rst_ovr", ovr, 0);

        // Up-slew on channel a, ticks 10 clocks apart
        div = 16'd9; step = 24'h010000;
        wr_tgt(2'd0, 24'h130000);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_upd(40, n);
            if (k > 0) check("up_gap", n, 10);
            check("up_dac_a", dac_a, up_exp[k]);
            check("up_ch", upd_ch, 0);
            check("up_busy", busy, 1);
        end
        cyc();
        check("up_busy_fall", busy, 0);
        quiet(25, "up_hold");

        // Down-slew on channel d, last step clamped to the target
        step = 24'h300000;
        wr_tgt(2'd3, 24'h000001);
        for (int k = 0; k < 4; k++) begin
            wait_upd(40, n);
            if (k > 0) check("dn_gap", n, 10);
            check("dn_dac_d", dac_d, dn_exp[k]);
            check("dn_ch", upd_ch, 3);
        end
        quiet(25, "dn_hold");
        check("dn_final", dac_d, 32'h000001);
        en = 1'b0;
        cyc();

        // Collision: write channel b in its own scan cycle
        step = 24'h010000; div = 16'd0;
        en = 1'b1;
        cyc(); cyc();
        tgt_wr = 1'b1; tgt_ch = 2'd1; tgt_val = 24'h000000;
        cyc();
        tgt_wr = 1'b0;
        check("col_no_upd", upd, 0);
        check("col_dac_b_old", dac_b, 32'h4E0000);
        repeat (4) cyc();
        cyc();
        check("col_upd", upd, 1);
        check("col_ch", upd_ch, 1);
        check("col_dac_b_new", dac_b, 32'h4D0000);
        en = 1'b0;
        cyc();
        wr_tgt(2'd1, 24'h4D0000);

        // Overrun: tick every clock with channel c mismatched
        step = 24'h000001;
        wr_tgt(2'd2, 24'h750010);
        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            ovr_r[i]  = ovr;
            upd_r[i]  = upd;
            dacc_r[i] = dac_c;
        end
        en = 1'b0;
        upd_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("ovr_%0d", i), ovr_r[i], ovr_exp[i]);
            if (upd_r[i]) upd_cnt++;
        end
        check("ovr_upd_cnt", upd_cnt, 2);
        check("ovr_upd4", upd_r[4], 1);
        check("ovr_upd9", upd_r[9], 1);
        check("ovr_dac_c4", dacc_r[4], 32'h750001);
        check("ovr_dac_c9", dacc_r[9], 32'h750002);
        cyc();

        // Zero step: mismatch persists, nothing moves
        step = 24'h000000;
        en = 1'b1;
        quiet(20, "zs_no_upd");
        check("zs_dac_c", dac_c, 32'h750002);
        check("zs_busy", busy, 1);
        en = 1'b0;
        cyc();

        // Disable during SCAN1: ch1 steps, ch2/ch3 untouched
        step = 24'h000001;
        wr_tgt(2'd1, 24'h4D0100);
        wr_tgt(2'd3, 24'h000000);
        en = 1'b1;
        cyc(); cyc();
        en = 1'b0;
        cyc();
        check("dis_upd", upd, 1);
        check("dis_ch", upd_ch, 1);
        check("dis_dac_b", dac_b, 32'h4D0001);
        check("dis_idle", 32'(dut.state), 32'(ST_IDLE));
        quiet(10, "dis_quiet");
        check("dis_dac_c", dac_c, 32'h750002);
        check("dis_dac_d", dac_d, 32'h000001);

        // Asynchronous reset in the middle of SCAN2
        en = 1'b1;
        cyc(); cyc(); cyc();
        check("pre_rst_scan2", 32'(dut.state), 32'(ST_SCAN2));
        rstn = 1'b0;
        #1;
        check("arst_dac_a", dac_a, 32'h0F0000);
        check("arst_dac_b", dac_b, 32'h4E0000);
        check("arst_dac_c", dac_c, 32'h750000);
        check("arst_dac_d", dac_d, 32'h9C0000);
        check("arst_busy", busy, 0);
        check("arst_ovr", ovr, 0);
        check("arst_idle", 32'(dut.state), 32'(ST_IDLE));
        en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        cyc();
        check("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_slew_sched.md
# pwm_slew_sched

Slew-rate scheduler for the four PWM DAC configuration words (24-bit duty/modulation format, `dac_a_o`..`dac_d_o`). Software writes a per-channel target. A single time-shared step engine moves each output toward its target by at most `step_i` per update tick, serving the channels round-robin. This prevents large instantaneous duty jumps on the analog PWM outputs. The block sits between the system-bus register file and the PWM generators, and replaces direct register-to-DAC writes.

## Interface
- `CH`, 4: number of PWM channels (fixed at 4; `ch` index is 2 bits)
- `CCW`, 24: configuration word width
- `DIVW`, 16: tick divider width

Ports:
- `clk_i`  in  1  clock; the design's PWM clock domain
- `rstn_i`  in  1  reset; one clock, reset asynchronous and active-low
- `en_i`  in  1  scheduler enable
- `div_i`  in  DIVW  tick period minus 1, in clocks
- `step_i`  in  CCW  maximum change per channel per tick (unsigned)
- `tgt_wr_i`  in  1  target write strobe, single-cycle
- `tgt_ch_i`  in  2  target channel (0=a .. 3=d)
- `tgt_val_i`  in  CCW  target value
- `dac_a_o`..`dac_d_o`  out  CCW each  current PWM configuration words (registered)
- `busy_o`  out  1  high while any channel differs from its target
- `upd_o`  out  1  one-cycle pulse when a `dac_*_o` changed value
- `upd_ch_o`  out  2  channel changed; valid with `upd_o`
- `ovr_o`  out  1  one-cycle pulse when a tick is dropped

## Operation
- **Reset values:**
  - `dac_a_o` = 0x0F0000, `dac_b_o` = 0x4E0000, `dac_c_o` = 0x750000, `dac_d_o` = 0x9C0000.
  - Each target equals its output's reset value.
  - Divider = 0; pending flag = 0; FSM = IDLE.
  - `busy_o`, `upd_o`, `upd_ch_o`, `ovr_o` = 0.
- **Target write:**
  - On `tgt_wr_i`, `tgt[tgt_ch_i]` is loaded with `tgt_val_i`.
  - The write is accepted in every state and regardless of `en_i`.
- **Divider:**
  - With `en_i` = 1, the counter counts 0..`div_i` and wraps.
  - `tick` is asserted in the cycle where count == `div_i`.
  - `div_i` = 0 gives a tick every clock.
  - With `en_i` = 0, the counter is held at 0.
- **FSM states:** IDLE, SCAN0, SCAN1, SCAN2, SCAN3.
  - IDLE → SCAN0 on `tick` or when the pending flag is set; the flag is cleared on entry.
  - SCANk → SCANk+1 unconditionally; SCAN3 → IDLE.
  - In SCANk, channel k is processed.
- **Step rule (channel k):**
  - d = `tgt[k]` − `cur[k]`, unsigned magnitude, CCW+1-bit compare.
  - If `cur` < `tgt`: `cur` += min(`step_i`, \|d\|).
  - If `cur` > `tgt`: `cur` −= min(`step_i`, \|d\|).
  - If equal, no change.
  - No overshoot and no wrap-around is possible.
- **`step_i` = 0:** outputs hold; `busy_o` remains high if any mismatch exists.
- **Tick during SCANx:**
  - The pending flag is set.
  - If the flag is already set, the tick is dropped and `ovr_o` pulses.
- **Simultaneous events:**
  - A write to channel k during SCANk: the step uses the old target; the new target applies from the next tick.
  - A write and a tick in the same cycle: both take effect.
- **Disable:**
  - `en_i` falling during SCAN forces IDLE next cycle and clears the pending flag.
  - The channel under processing in that cycle still completes its step.
  - Outputs hold.
- **`busy_o`:** registered OR over k of (`cur[k]` ≠ `tgt[k]`).

## Timing
- Tick at cycle T → SCAN0 at T+1.
- Channel k's new value is visible on `dac_*_o` at T+2+k.
- `upd_o`/`upd_ch_o` are asserted in the same cycle the new value is visible.
- Worst-case settle time: ceil(\|Δ\| / `step_i`) ticks.
- Sustained rate without overrun requires `div_i` ≥ 4.
  - For `div_i` < 4, one pending tick is queued and further ticks are dropped with `ovr_o`.
- `busy_o` lags the state by 1 cycle.
- Asynchronous reset takes effect immediately, mid-scan included, and restores all reset values.

## Structure
- Shared package `pwm_pkg`:
  - `CCW` = 24
  - reset constants `PWM_RST_A..D`
  - scheduler state enum `sched_st_t`
- Sub-module `pwm_slew_step`: combinational (`cur`, `tgt`, `step`) → `next`, plus a `changed` flag.
  - It is instantiated once and muxed by the scan index.
- Storage: the `cur` and `tgt` arrays are flops, 4×24 each.

## Test plan
- **Reset:**
  - Assert `rstn_i` = 0 mid-SCAN2 → outputs return to 0x0F0000/0x4E0000/0x750000/0x9C0000 immediately.
  - `busy_o` = 0 and the FSM is in IDLE.
- **Up-slew:**
  - Setup: `div_i` = 9, `step_i` = 0x010000; write ch0 target 0x130000.
  - `dac_a_o` steps to 0x100000, 0x110000, 0x120000, 0x130000 on consecutive ticks (10 clocks apart).
  - `upd_ch_o` = 0 each step; `busy_o` then falls.
- **Down-slew without overshoot:**
  - Setup: `step_i` = 0x300000; write ch3 target 0x000001.
  - `dac_d_o` goes 0x9C0000 → 0x6C0000 → 0x3C0000 → 0x0C0000 → 0x000001, then holds.
- **Overrun:**
  - Setup: `div_i` = 0, one channel mismatched.
  - Pending is set on the first tick.
  - The second tick within the same scan pulses `ovr_o`.
  - Scans repeat back-to-back with 1 IDLE cycle between them.
- **Collision:**
  - Setup: write ch1 target 0x000000 in the SCAN1 cycle while the prior target is 0x4E0000 (no change pending).
  - No change that tick; slewing starts the next tick.
- **Disable/zero step:**
  - `step_i` = 0 with a mismatch → outputs constant, `busy_o` = 1.
  - `en_i` = 0 mid-SCAN1 → IDLE next cycle; ch1 stepped, ch2/ch3 not.
